// File: rtl/alu_result_buffer_pkg.sv
// Shared ALU types: opcode tags, buffered result entry and accumulator bounds
// used by the result buffer and its FIFO.
package alu_result_buffer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_t;

  localparam int DATA_W     = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int ACC_W      = 8;

  typedef struct packed {
    opcode_t                  op;
    logic signed [DATA_W-1:0] data;
  } result_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Sums are formed one bit wider than the accumulator so they never wrap before clamping.
  function automatic logic sat_hit(input logic signed [ACC_W:0] sum);
    return (sum > (ACC_W+1)'(ACC_MAX)) || (sum < (ACC_W+1)'(ACC_MIN));
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] sum);
    if (sum > (ACC_W+1)'(ACC_MAX)) return ACC_MAX;
    if (sum < (ACC_W+1)'(ACC_MIN)) return ACC_MIN;
    return sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Valid/ready result channel between the ALU, the result buffer and its consumer.
interface alu_result_buffer_if
  import alu_result_buffer_pkg::*;
();

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  opcode_t                  in_opcode;
  logic                     in_ready;

  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  opcode_t                  out_opcode;
  logic                     out_ready;

  modport RESULT_SRC (output in_valid, in_data, in_opcode, input in_ready);

  modport RESULT_SINK (input out_valid, out_data, out_opcode, output out_ready);

  modport BUFFER (
    input  in_valid, in_data, in_opcode,
    output in_ready,
    output out_valid, out_data, out_opcode,
    input  out_ready
  );

endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO of ALU result entries; ready/valid come from
// the registered occupancy only, so there is no ready-to-ready combinational path.
module alu_result_fifo
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  result_t                  wr_entry,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output result_t                  rd_entry,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  result_t          mem_q [DEPTH];
  result_t          mem_d [DEPTH];
  logic             push, pop;

  assign wr_ready = (count_q != CNT_W'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  // DEPTH is a power of two, so pointer increments wrap to 0 on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count says they are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: FIFO of tagged results plus a saturating running sum of
// every accepted result with a sticky saturation flag.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_result_buffer_if.BUFFER      bus,
  input  logic                     clear_acc,
  output logic [$clog2(DEPTH):0]   count,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     acc_ovf
);

  result_t                 wr_entry;
  result_t                 rd_entry;
  logic                    push;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic                    acc_ovf_q, acc_ovf_d;
  logic signed [ACC_W:0]   sum;

  assign wr_entry.op   = bus.in_opcode;
  assign wr_entry.data = bus.in_data;

  alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (bus.in_valid),
    .wr_entry (wr_entry),
    .wr_ready (bus.in_ready),
    .rd_valid (bus.out_valid),
    .rd_entry (rd_entry),
    .rd_ready (bus.out_ready),
    .count    (count)
  );

  assign bus.out_data   = rd_entry.data;
  assign bus.out_opcode = rd_entry.op;
  assign push           = bus.in_valid & bus.in_ready;
  assign acc            = acc_q;
  assign acc_ovf        = acc_ovf_q;

  // A clear in the same cycle as a push zeroes the sum first, then adds the new result.
  always_comb begin
    acc_base  = clear_acc ? '0 : acc_q;
    sum       = (ACC_W+1)'(acc_base) + (ACC_W+1)'(bus.in_data);
    acc_d     = acc_base;
    acc_ovf_d = clear_acc ? 1'b0 : acc_ovf_q;
    if (push) begin
      acc_d     = sat_acc(sum);
      acc_ovf_d = acc_ovf_d | sat_hit(sum);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: directed corner cases then random traffic,
// checked against a queue-and-integer model of the buffer and accumulator.
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int AMAX  = 127;
  localparam int AMIN  = -128;

  typedef struct {
    int data;
    int op;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    clear_acc = 1'b0;
  logic [3:0]              count;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_ovf;

  alu_result_buffer_if bus ();

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clear_acc (clear_acc),
    .count     (count),
    .acc       (acc),
    .acc_ovf   (acc_ovf)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   m_count = 0;
  int   m_acc = 0;
  int   m_ovf = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input int d, input int op,
                               input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = 5'(d);
    bus.in_opcode = opcode_t'(op[2:0]);
    bus.out_ready = ordy;
    clear_acc     = clr;
  endtask

  // Reference model: occupancy, queued entries and accumulator from plain integer rules.
  always @(posedge clk or negedge reset) begin
    int   nxt;
    int   base_ovf;
    bit   do_push, do_pop;
    exp_t e;
    if (!reset) begin
      sb.delete();
      m_count = 0;
      m_acc   = 0;
      m_ovf   = 0;
    end else begin
      do_push  = bus.in_valid && (m_count < DEPTH);
      do_pop   = (m_count > 0) && bus.out_ready;
      base_ovf = clear_acc ? 0 : m_ovf;
      nxt      = clear_acc ? 0 : m_acc;
      if (do_push) begin
        e.data = int'(bus.in_data);
        e.op   = int'(bus.in_opcode);
        sb.push_back(e);
        nxt = nxt + e.data;
        if (nxt > AMAX) begin nxt = AMAX; base_ovf = 1; end
        if (nxt < AMIN) begin nxt = AMIN; base_ovf = 1; end
      end
      m_acc   = nxt;
      m_ovf   = base_ovf;
      m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
  end

  // Monitor: compares status every cycle and pops the expected head on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      checkOutput("count", int'(count), m_count);
      checkOutput("in_ready", int'(bus.in_ready), (m_count < DEPTH) ? 1 : 0);
      checkOutput("out_valid", int'(bus.out_valid), (m_count > 0) ? 1 : 0);
      checkOutput("acc", int'(acc), m_acc);
      checkOutput("acc_ovf", int'(acc_ovf), m_ovf);
      if (m_count > 0) begin
        if (sb.size() == 0) begin
          checkOutput("scoreboard_size", 0, m_count);
        end else begin
          e = sb[0];
          checkOutput("out_data", int'(bus.out_data), e.data);
          checkOutput("out_opcode", int'(bus.out_opcode), e.op);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int budget = 0;
    applyStimulus(0, 0, 0, 1, 0);
    while (m_count > 0 && budget < 50) begin
      applyStimulus(0, 0, 0, 1, 0);
      budget++;
    end
    if (m_count > 0) checkOutput("drain_timeout", m_count, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_opcode = OP_ADD;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_in_ready", int'(bus.in_ready), 1);
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    reset = 1'b1;

    // Fill to full, hold a ninth, then drain in order.
    for (int i = 1; i <= 8; i++) applyStimulus(1, i, i % 8, 0, 0);
    applyStimulus(1, 9, 1, 0, 0);
    applyStimulus(1, 9, 1, 0, 0);
    checkOutput("full_count", int'(count), 8);
    checkOutput("full_in_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("empty_count", int'(count), 0);
    checkOutput("empty_out_valid", int'(bus.out_valid), 0);

    // Steady push+pop at occupancy 3 across the pointer wrap.
    for (int i = 0; i < 3; i++) applyStimulus(1, 10 + i, i, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("steady_count", int'(count), 3);
    drain();

    // Positive saturation.
    applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 15, 0, 1, 0);
    applyStimulus(1, 15, 0, 1, 0);
    checkOutput("acc_after_8x15", int'(acc), 120);
    applyStimulus(1, -16, 1, 1, 0);
    checkOutput("acc_sat_pos", int'(acc), 127);
    checkOutput("ovf_sat_pos", int'(acc_ovf), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("acc_after_neg", int'(acc), 111);
    checkOutput("ovf_sticky", int'(acc_ovf), 1);

    // Negative saturation, then clear combined with a push.
    applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) applyStimulus(1, -16, 1, 1, 0);
    applyStimulus(1, -5, 2, 1, 1);
    checkOutput("acc_sat_neg", int'(acc), -128);
    checkOutput("ovf_sat_neg", int'(acc_ovf), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("acc_clear_push", int'(acc), -5);
    checkOutput("ovf_clear_push", int'(acc_ovf), 0);
    drain();

    // Single-entry fall-through with the consumer always ready.
    applyStimulus(1, -3, int'(OP_SUB), 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("fwft_valid", int'(bus.out_valid), 1);
    checkOutput("fwft_data", int'(bus.out_data), -3);
    checkOutput("fwft_opcode", int'(bus.out_opcode), int'(OP_SUB));
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("fwft_count", int'(count), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));

    // Asynchronous reset with five entries held.
    drain();
    for (int i = 1; i <= 5; i++) applyStimulus(1, i, i, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pre_reset_count", int'(count), 5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_count", int'(count), 0);
    checkOutput("mid_reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("mid_reset_in_ready", int'(bus.in_ready), 1);
    checkOutput("mid_reset_acc", int'(acc), 0);
    checkOutput("mid_reset_ovf", int'(acc_ovf), 0);
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
